// File: rtl/fp_add_scheduler_if.sv
// Handshake bundle between two requesters and fp_add_scheduler.
// The per-requester subtract flags exist only when FPA_SCHED_SUB_EN is defined.
interface fp_add_scheduler_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req1_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req0_ready;
  logic             req1_ready;
  logic             rsp0_valid;
  logic             rsp1_valid;
  logic             rsp0_ready;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_cout;
`ifdef FPA_SCHED_SUB_EN
  logic             req0_sub;
  logic             req1_sub;

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_sub, req1_sub, rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_cout
  );
  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_sub, req1_sub, rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_cout
  );
`else
  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_cout
  );
  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_cout
  );
`endif
endinterface

// File: rtl/fp_add_scheduler.sv
// Round-robin scheduler sharing one fixed-latency floating adder between two requesters.
// Optional macro FPA_SCHED_SUB_EN adds per-request subtract (sign flip of operand b).
module fp_add_scheduler #(
  parameter int ADD_LAT = 2,
  parameter int WIDTH   = 32
) (
  input  logic              clk,
  input  logic              rst,
  fp_add_scheduler_if.slave bus,
  output logic [WIDTH-1:0]  fa_a,
  output logic [WIDTH-1:0]  fa_b,
  input  logic [WIDTH-1:0]  fa_out,
  input  logic              fa_cout
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] BUSY     = 2'd1;
  localparam logic [1:0] RESP     = 2'd2;
  localparam logic [3:0] LAST_CNT = 4'(ADD_LAT - 1);

  logic [1:0]       state;
  logic [3:0]       busy_cnt;
  logic             rr_ptr;
  logic             gnt_id;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res_data;
  logic             res_cout;
  logic             grant0;
  logic             grant1;
  logic             rsp_take;

  // Grant decision: rr_ptr names the favoured requester when both are pending.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && state == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = !rr_ptr;
        grant1 = rr_ptr;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end else begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end
  end

  assign rsp_take       = gnt_id ? bus.rsp1_ready : bus.rsp0_ready;
  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.rsp0_valid = (state == RESP) && !gnt_id;
  assign bus.rsp1_valid = (state == RESP) && gnt_id;
  assign bus.rsp_data   = res_data;
  assign bus.rsp_cout   = res_cout;
  assign fa_a           = op_a;

`ifdef FPA_SCHED_SUB_EN
  logic op_sub;
  assign fa_b = {op_b[WIDTH-1] ^ op_sub, op_b[WIDTH-2:0]};

  // Subtract flag captured with the operands of the granted requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_sub <= 1'b0;
    end else if (grant0 || grant1) begin
      op_sub <= grant1 ? bus.req1_sub : bus.req0_sub;
    end
  end
`else
  assign fa_b = op_b;
`endif

  // Controller: accept in IDLE, wait out the adder latency, hold result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy_cnt <= 4'd0;
      rr_ptr   <= 1'b0;
      gnt_id   <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      res_data <= '0;
      res_cout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            op_a     <= grant1 ? bus.req1_a : bus.req0_a;
            op_b     <= grant1 ? bus.req1_b : bus.req0_b;
            gnt_id   <= grant1;
            rr_ptr   <= grant0;
            busy_cnt <= 4'd0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (busy_cnt == LAST_CNT) begin
            res_data <= fa_out;
            res_cout <= fa_cout;
            busy_cnt <= 4'd0;
            state    <= RESP;
          end else begin
            busy_cnt <= busy_cnt + 4'd1;
          end
        end
        RESP: begin
          if (rsp_take) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Scoreboard bench for fp_add_scheduler: randomized fixed-point-valued float operands,
// a reference arbiter/latency model, and a bench-side adder with ADD_LAT-1 register stages.
module tb_fp_add_scheduler;
  localparam int WIDTH   = 32;
  localparam int ADD_LAT = 2;

  logic clk = 1'b0;
  logic rst;
  logic [WIDTH-1:0] fa_a, fa_b, fa_out;
  logic fa_cout;

  always #5 clk = ~clk;

  fp_add_scheduler_if #(.WIDTH(WIDTH)) bus ();

  fp_add_scheduler #(.ADD_LAT(ADD_LAT), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .fa_a(fa_a), .fa_b(fa_b), .fa_out(fa_out), .fa_cout(fa_cout)
  );

  // Values are carried as signed fixed point with 8 fraction bits (q8).
  function automatic logic [31:0] q8_to_fp(input longint v);
    longint mag;
    int p;
    logic [31:0] r;
    if (v == 0) return 32'd0;
    mag = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 40; i++) if (mag[i]) p = i;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + p - 8);
    if (p >= 23) r[22:0] = 23'(mag >> (p - 23));
    else         r[22:0] = 23'(mag << (23 - p));
    return r;
  endfunction

  function automatic longint fp_to_q8(input logic [31:0] f);
    longint m;
    int sh;
    if (f[30:23] == 8'd0) return 64'sd0;
    m  = longint'({8'd0, 1'b1, f[22:0]});
    sh = int'(f[30:23]) - 142;
    if (sh >= 0) m = m << sh;
    else         m = m >> (-sh);
    return f[31] ? -m : m;
  endfunction

  // Bench-side adder: sum of operand values, valid ADD_LAT-1 cycles after operands settle.
  logic [32:0] raw_sum;
  assign raw_sum = {1'b0, fa_a} + {1'b0, fa_b};
  always @(posedge clk) begin
    fa_out  <= q8_to_fp(fp_to_q8(fa_a) + fp_to_q8(fa_b));
    fa_cout <= raw_sum[32];
  end

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        cout;
    int          acc_cyc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_gnt = 1;
  int          win, ew, vid;
  logic        in_rsp = 1'b0;
  int          rsp_id;
  logic [31:0] held_data;
  logic        held_cout;
  logic        acc_flag [2];
  longint      cur_x [2];
  longint      cur_y [2];
  logic        cur_sub [2];
  int          rdy_mode = 0;
  logic [32:0] ref_sum;
  logic [31:0] ref_b;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor/scoreboard: acceptance, arbitration, latency and response checks.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sbq.delete();
      in_rsp   = 1'b0;
      last_gnt = 1;
    end else begin
      if (bus.req0_ready || bus.req1_ready) begin
        check("one_ready", longint'(bus.req0_ready & bus.req1_ready), 0);
        check("ready_while_busy", longint'(sbq.size() != 0 || in_rsp), 0);
        win = bus.req1_ready ? 1 : 0;
        if (bus.req0_valid && bus.req1_valid) ew = (last_gnt == 0) ? 1 : 0;
        else ew = bus.req1_valid ? 1 : 0;
        check("arb_winner", win, ew);
        check("ready_without_valid", longint'(win == 1 ? bus.req1_valid : bus.req0_valid), 1);
        e.id      = win;
        e.data    = q8_to_fp(cur_sub[win] ? cur_x[win] - cur_y[win] : cur_x[win] + cur_y[win]);
        ref_b     = q8_to_fp(cur_y[win]) ^ (cur_sub[win] ? 32'h8000_0000 : 32'h0);
        ref_sum   = {1'b0, q8_to_fp(cur_x[win])} + {1'b0, ref_b};
        e.cout    = ref_sum[32];
        e.acc_cyc = cyc;
        sbq.push_back(e);
        last_gnt      = win;
        acc_flag[win] = 1'b1;
      end else if ((bus.req0_valid || bus.req1_valid) && sbq.size() == 0 && !in_rsp) begin
        check("grant_when_idle", 0, 1);
      end

      if (bus.rsp0_valid || bus.rsp1_valid) begin
        check("single_rsp_valid", longint'(bus.rsp0_valid & bus.rsp1_valid), 0);
        vid = bus.rsp1_valid ? 1 : 0;
        if (!in_rsp) begin
          if (sbq.size() == 0) begin
            check("spurious_rsp", 1, 0);
          end else begin
            e = sbq.pop_front();
            check("rsp_id", vid, e.id);
            check("rsp_data", bus.rsp_data, e.data);
            check("rsp_cout", longint'(bus.rsp_cout), longint'(e.cout));
            check("latency", cyc - e.acc_cyc, 1 + ADD_LAT);
            in_rsp    = 1'b1;
            rsp_id    = vid;
            held_data = bus.rsp_data;
            held_cout = bus.rsp_cout;
          end
        end else begin
          check("rsp_hold_id", vid, rsp_id);
          check("rsp_hold_data", bus.rsp_data, held_data);
          check("rsp_hold_cout", longint'(bus.rsp_cout), longint'(held_cout));
        end
        if ((vid == 0 && bus.rsp0_ready) || (vid == 1 && bus.rsp1_ready)) in_rsp = 1'b0;
      end else begin
        if (in_rsp) begin
          check("rsp_dropped", 1, 0);
          in_rsp = 1'b0;
        end
        if (sbq.size() != 0 && cyc - sbq[0].acc_cyc > 3 + ADD_LAT) begin
          check("rsp_timeout", 0, 1);
          void'(sbq.pop_front());
        end
      end
    end
  end

  // Response-ready driver: 0 always ready, 1 random, 2 held low.
  initial begin
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       begin bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1; end
        1:       begin bus.rsp0_ready = ($urandom_range(0, 3) != 0); bus.rsp1_ready = ($urandom_range(0, 3) != 0); end
        default: begin bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0; end
      endcase
    end
  end

  task automatic send(input int id, input longint x, input longint y, input logic sub);
    cur_x[id]    = x;
    cur_y[id]    = y;
    cur_sub[id]  = 1'b0;
    acc_flag[id] = 1'b0;
`ifdef FPA_SCHED_SUB_EN
    cur_sub[id] = sub;
    if (id == 0) bus.req0_sub = sub; else bus.req1_sub = sub;
`endif
    if (id == 0) begin
      bus.req0_a = q8_to_fp(x); bus.req0_b = q8_to_fp(y); bus.req0_valid = 1'b1;
    end else begin
      bus.req1_a = q8_to_fp(x); bus.req1_b = q8_to_fp(y); bus.req1_valid = 1'b1;
    end
    for (int k = 0; k < 300 && !acc_flag[id]; k++) @(posedge clk);
    if (!acc_flag[id]) check("accept_timeout", 0, 1);
    #1;
    if (id == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
  endtask

  task automatic wait_rsp0(input string name);
    int k;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.rsp0_valid) break;
    end
    if (k == 20) check(name, 0, 1);
  endtask

  task automatic rand_stream(input int id, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      send(id, longint'($urandom_range(0, 1 << 20)) - (1 << 19),
               longint'($urandom_range(0, 1 << 20)) - (1 << 19), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    logic [31:0] cap;
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_a = '0; bus.req0_b = '0; bus.req1_a = '0; bus.req1_b = '0;
`ifdef FPA_SCHED_SUB_EN
    bus.req0_sub = 1'b0; bus.req1_sub = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_rsp0_valid", longint'(bus.rsp0_valid), 0);
    check("rst_rsp1_valid", longint'(bus.rsp1_valid), 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_cout", longint'(bus.rsp_cout), 0);
    check("rst_fa_a", fa_a, 0);
    check("rst_fa_b", fa_b, 0);
    check("rst_ready", longint'(bus.req0_ready | bus.req1_ready), 0);
    @(posedge clk); #1;

    // Simultaneous 1.0+1.0 pairs: req0, then req1, then req0 again.
    fork send(0, 256, 256, 1'b0); send(1, 256, 256, 1'b0); join
    fork send(0, 256, 256, 1'b0); send(1, 256, 256, 1'b0); join
    repeat (6) begin @(posedge clk); #1; end

    // -2.0 + -3.5 = -5.5 on requester 0.
    send(0, -512, -896, 1'b0);
    wait_rsp0("single_add_wait");
    check("single_add_data", bus.rsp_data, 32'hC0B0_0000);
    check("single_add_rsp1", longint'(bus.rsp1_valid), 0);
    repeat (3) begin @(posedge clk); #1; end

    // Backpressure on requester 0 with requester 1 pending.
    rdy_mode = 2;
    send(0, 1000, 24, 1'b0);
    fork send(1, 300, 40, 1'b0); join_none
    wait_rsp0("bp_wait");
    cap = bus.rsp_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", longint'(bus.rsp0_valid), 1);
      check("bp_data", bus.rsp_data, cap);
      check("bp_req1_ready", longint'(bus.req1_ready), 0);
    end
    rdy_mode = 0;
    wait fork;
    repeat (6) begin @(posedge clk); #1; end

    // Reset during the second BUSY cycle aborts the operation.
    send(0, 77, 99, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_valid", longint'(bus.rsp0_valid | bus.rsp1_valid), 0);
    check("abort_data", bus.rsp_data, 0);
    check("abort_fa_a", fa_a, 0);
    check("abort_fa_b", fa_b, 0);
    repeat (5) begin @(posedge clk); #1; end
    fork send(0, 10, 20, 1'b0); send(1, 30, 40, 1'b0); join
    repeat (6) begin @(posedge clk); #1; end

`ifdef FPA_SCHED_SUB_EN
    send(1, 768, 256, 1'b1);
    check("sub_fa_b", fa_b, 32'hBF80_0000);
    repeat (6) begin @(posedge clk); #1; end
`endif

    rdy_mode = 1;
    fork rand_stream(0, 60); rand_stream(1, 60); join
    rdy_mode = 0;
    repeat (20) begin @(posedge clk); #1; end
    if (sbq.size() != 0) check("drain", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
